// File: rtl/cm_scheduler.sv
// ---------------------------------------------------------------------------
// cm_scheduler
// Shares one combinational custom_matrix block between NREQ requesters.
// A round-robin arbiter grants one requester while idle, its operand is
// presented on cm_in, the matrix result is registered one cycle later and
// held on the response port until the consumer takes it.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst_n      : asynchronous active-low reset
//   req_valid  : per-requester operand valid            [NREQ]
//   req_data   : operands, requester i at [i*W +: W]     [NREQ*W]
//   req_ready  : one-hot accept strobe (IDLE only)       [NREQ]
//   cm_in      : operand driven to the shared matrix     [W]
//   cm_out     : combinational matrix result             [W]
//   rsp_valid  : response valid
//   rsp_data   : registered matrix result                [W]
//   rsp_id     : requester that owns rsp_data            [2]
//   rsp_ready  : consumer accepts the response
//   busy       : FSM is not in IDLE
//   op_count   : completed operations, wraps mod 256     [8]
// ---------------------------------------------------------------------------
module cm_scheduler #(
    parameter int NREQ = 4,
    parameter int W    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic [W-1:0]      cm_in,
    input  logic [W-1:0]      cm_out,
    output logic              rsp_valid,
    output logic [W-1:0]      rsp_data,
    output logic [1:0]        rsp_id,
    input  logic              rsp_ready,
    output logic              busy,
    output logic [7:0]        op_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t         r_state;
    logic [1:0]     r_rr_ptr;
    logic [W-1:0]   r_operand;
    logic [W-1:0]   r_rsp_data;
    logic [1:0]     r_rsp_id;
    logic           r_rsp_valid;
    logic [7:0]     r_op_count;
    // Low for the first cycle after reset release so no request is
    // accepted before the first clock edge has been seen.
    logic           r_armed;

    logic [3:0]     w_valid4;
    logic [3:0]     w_ready4;
    logic           w_found;
    logic [1:0]     w_winner;
    logic [W-1:0]   w_win_data;
    logic           w_accept;
    logic [1:0]     w_next_ptr;

    // Widen the request vector to the 4-entry maximum so the search can
    // index it with a fixed 2-bit index for any legal NREQ.
    always_comb begin
        w_valid4             = '0;
        w_valid4[NREQ-1:0]   = req_valid;
    end

    // Round-robin search: starting at r_rr_ptr, the first valid index wins.
    always_comb begin : rr_search
        logic [2:0] idx;
        idx      = '0;
        w_found  = 1'b0;
        w_winner = r_rr_ptr;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, r_rr_ptr} + 3'(k);
            if (idx >= 3'(NREQ)) begin
                idx = idx - 3'(NREQ);
            end
            if (!w_found && w_valid4[idx[1:0]]) begin
                w_found  = 1'b1;
                w_winner = idx[1:0];
            end
        end
    end

    always_comb begin
        w_win_data = req_data[int'(w_winner)*W +: W];
    end

    assign w_accept = (r_state == S_IDLE) && r_armed && w_found;

    always_comb begin
        w_ready4 = '0;
        if (w_accept) begin
            w_ready4[w_winner] = 1'b1;
        end
    end

    // Pointer moves to the requester after the one just served.
    assign w_next_ptr = (r_rsp_id == 2'(NREQ - 1)) ? 2'd0 : (r_rsp_id + 2'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_operand   <= '0;
            r_rsp_data  <= '0;
            r_rsp_id    <= '0;
            r_rsp_valid <= 1'b0;
            r_op_count  <= '0;
            r_armed     <= 1'b0;
        end else begin
            r_armed <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_operand <= w_win_data;
                        r_rsp_id  <= w_winner;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_rsp_data  <= cm_out;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rr_ptr    <= w_next_ptr;
                        r_op_count  <= r_op_count + 8'd1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready = w_ready4[NREQ-1:0];
    assign cm_in     = r_operand;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_id    = r_rsp_id;
    assign busy      = (r_state != S_IDLE);
    assign op_count  = r_op_count;

endmodule

// File: tb/tb_cm_scheduler.sv
// ---------------------------------------------------------------------------
// tb_cm_scheduler
// Scoreboard bench: the stimulus side predicts each grant with a plain
// round-robin model and pushes the expected response; a negedge monitor
// pops and compares whenever the scheduler presents a response.
// ---------------------------------------------------------------------------
module tb_cm_scheduler;

    localparam int NREQ = 4;
    localparam int W    = 4;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic [W-1:0]      cm_in;
    logic [W-1:0]      cm_out;
    logic              rsp_valid;
    logic [W-1:0]      rsp_data;
    logic [1:0]        rsp_id;
    logic              rsp_ready;
    logic              busy;
    logic [7:0]        op_count;

    cm_scheduler #(.NREQ(NREQ), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .cm_in     (cm_in),
        .cm_out    (cm_out),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_ready (rsp_ready),
        .busy      (busy),
        .op_count  (op_count)
    );

    // Stand-in for the shared custom_matrix: rotate left and xor a constant.
    function automatic logic [3:0] cm_model(input logic [3:0] x);
        return {x[2:0], x[3]} ^ 4'h9;
    endfunction

    assign cm_out = cm_model(cm_in);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [1:0] id;
        logic [3:0] data;
        int         rise;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int         m_ptr    = 0;
    int         n_done   = 0;
    int         last_acc = -1;

    // Monitor state
    logic       mon_have    = 1'b0;
    logic       mon_pending = 1'b0;
    logic [7:0] mon_count   = 8'd0;
    exp_t       mon_cur;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (mon_pending) begin
                check("op_count", 32'(op_count), 32'(mon_count));
                mon_pending = 1'b0;
            end
            if (rsp_valid) begin
                if (!mon_have) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_rsp", 32'(rsp_valid), 32'd0);
                    end else begin
                        mon_cur = exp_q.pop_front();
                        check("rsp_id", 32'(rsp_id), 32'(mon_cur.id));
                        check("rsp_data", 32'(rsp_data), 32'(mon_cur.data));
                        check("rsp_latency", 32'(cyc), 32'(mon_cur.rise));
                        $display("rsp id=%0d data=%0h cycle=%0d", rsp_id, rsp_data, cyc);
                        mon_have = 1'b1;
                    end
                end else begin
                    check("hold_data", 32'(rsp_data), 32'(mon_cur.data));
                    check("hold_id", 32'(rsp_id), 32'(mon_cur.id));
                    check("hold_ready", 32'(req_ready), 32'd0);
                    check("hold_busy", 32'(busy), 32'd1);
                end
                if (rsp_ready && mon_have) begin
                    mon_count   = mon_count + 8'd1;
                    mon_pending = 1'b1;
                    mon_have    = 1'b0;
                end
            end
        end
    end

    task automatic garbage();
        req_valid = NREQ'($urandom);
        req_data  = (NREQ*W)'($urandom);
    endtask

    // Issue one request cycle; called #1 after a rising edge with the DUT idle.
    // Returns #1 after the completion edge (or after one cycle if nothing won).
    task automatic do_op(input logic [3:0] mask, input logic [15:0] data, input int hold,
                         output int acc_cyc);
        logic [1:0] win;
        logic       found;
        logic [3:0] exp_ready;
        exp_t       e;
        int         hc;
        logic       done;
        found     = 1'b0;
        win       = 2'd0;
        acc_cyc   = -1;
        req_valid = mask[NREQ-1:0];
        req_data  = data[NREQ*W-1:0];
        rsp_ready = (hold == 0);
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (m_ptr + k) % NREQ;
            if (!found && mask[idx]) begin
                found = 1'b1;
                win   = 2'(idx);
            end
        end
        @(negedge clk);
        exp_ready = found ? (4'b0001 << win) : 4'b0000;
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        if (!found) begin
            check("idle_busy", 32'(busy), 32'd0);
            @(posedge clk);
            #1;
            return;
        end
        e.id   = win;
        e.data = cm_model(data[int'(win)*4 +: 4]);
        e.rise = cyc + 2;
        exp_q.push_back(e);
        acc_cyc = cyc;
        $display("grant req=%0d operand=%0h cycle=%0d", win, data[int'(win)*4 +: 4], cyc);
        m_ptr = (int'(win) + 1) % NREQ;
        @(posedge clk);
        #1;
        check("cm_in", 32'(cm_in), 32'(data[int'(win)*4 +: 4]));
        garbage();
        rsp_ready = (hold == 0);
        hc   = hold;
        done = 1'b0;
        for (int t = 0; t < 40 && !done; t++) begin
            @(posedge clk);
            #1;
            if (!busy) begin
                done = 1'b1;
            end else begin
                garbage();
                if (rsp_valid) begin
                    if (hc > 0) begin
                        rsp_ready = 1'b0;
                        hc--;
                    end else begin
                        rsp_ready = 1'b1;
                    end
                end
            end
        end
        check("op_timeout", 32'(done), 32'd1);
        n_done++;
    endtask

    initial begin
        int   acc;
        logic [15:0] d;
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = 1'b0;
        #3;
        // Reset state
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_op_count", 32'(op_count), 32'd0);
        check("rst_cm_in", 32'(cm_in), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Round-robin fairness, all requesters valid, 3-cycle spacing
        last_acc = -1;
        for (int k = 0; k < 5; k++) begin
            do_op(4'b1111, 16'($urandom), 0, acc);
            if (k > 0) check("rr_spacing", 32'(acc - last_acc), 32'd3);
            last_acc = acc;
        end

        // Single request on requester 2 with operand A
        d = 16'($urandom);
        d[11:8] = 4'hA;
        do_op(4'b0100, d, 0, acc);

        // Backpressure for 5 cycles
        do_op(4'b0011, 16'($urandom), 5, acc);

        // Reset during ISSUE
        req_valid = 4'b0001;
        req_data  = 16'($urandom);
        rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        check("pre_reset_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_rsp_data", 32'(rsp_data), 32'd0);
        check("mid_rst_rsp_id", 32'(rsp_id), 32'd0);
        check("mid_rst_cm_in", 32'(cm_in), 32'd0);
        check("mid_rst_op_count", 32'(op_count), 32'd0);
        exp_q.delete();
        mon_have    = 1'b0;
        mon_pending = 1'b0;
        mon_count   = 8'd0;
        m_ptr       = 0;
        n_done      = 0;
        req_valid   = 4'b1000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_after_release", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        do_op(4'b1000, 16'($urandom), 0, acc);

        // Random traffic until 256 operations since reset
        for (int it = 0; it < 3000 && n_done < 256; it++) begin
            do_op(4'($urandom_range(0, 15)), 16'($urandom), int'($urandom_range(0, 3)), acc);
        end
        check("ops_done", 32'(n_done), 32'd256);
        check("op_count_wrap", 32'(op_count), 32'd0);

        req_valid = '0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cm_scheduler.md
CM_SCHEDULER -- requirements
Module: cm_scheduler

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing one custom_matrix instance; legal values are 2 to 4.
REQ-002 Parameter W, default 4, width of the matrix input and output in bits.
REQ-003 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1; reset is asynchronous and active-low.
REQ-005 Port req_valid, input, NREQ, per-requester operand valid.
REQ-006 Port req_data, input, NREQ*W, operands; requester i occupies bits [i*W +: W].
REQ-007 Port req_ready, output, NREQ, per-requester accept strobe; at most one bit is set.
REQ-008 Port cm_in, output, W, drives the shared custom_matrix input.
REQ-009 Port cm_out, input, W, combinational result returned by the shared custom_matrix.
REQ-010 Port rsp_valid, output, 1, result valid.
REQ-011 Port rsp_data, output, W, registered matrix result.
REQ-012 Port rsp_id, output, 2, index of the requester that owns rsp_data.
REQ-013 Port rsp_ready, input, 1, consumer accepts the result.
REQ-014 Port busy, output, 1, high whenever the FSM is not in IDLE.
REQ-015 Port op_count, output, 8, number of completed operations; wraps modulo 256.

Function
REQ-016 The FSM SHALL have three states: IDLE, ISSUE and RESP.
REQ-017 In IDLE with any req_valid bit set, the block SHALL select a winner by round-robin.
- Search starts at pointer rr_ptr and increments modulo NREQ.
- The first index with req_valid=1 wins.
REQ-018 In IDLE, req_ready[winner] SHALL be asserted combinationally in the same cycle.
- That cycle is the accept (handshake) cycle.
- All other req_ready bits SHALL be 0.
- Outside IDLE, every req_ready bit SHALL be 0.
REQ-019 On the accept edge, the block SHALL:
- latch the winner's req_data into the operand register;
- latch the winner index into rsp_id;
- move to ISSUE.
REQ-020 cm_in SHALL always equal the operand register, so it holds its last value when idle.
REQ-021 In ISSUE, on the next edge, the block SHALL:
- register cm_out into rsp_data;
- set rsp_valid=1;
- move to RESP.
REQ-022 Latency: rsp_valid SHALL rise exactly 2 cycles after the accept cycle's rising edge.
REQ-023 In RESP, rsp_valid, rsp_data and rsp_id SHALL hold stable until rsp_ready=1 is sampled.
REQ-024 On the RESP edge with rsp_ready=1, the block SHALL:
- clear rsp_valid;
- set rr_ptr = (rsp_id+1) mod NREQ;
- increment op_count (wrapping 255 to 0);
- return to IDLE.
REQ-025 There SHALL be no IDLE bypass: after a completed response, the next accept occurs no earlier than the cycle following the return to IDLE.
- Throughput is therefore at most 1 operation per 3 cycles.
REQ-026 A requester that drops req_valid before being granted SHALL not be served; no request is queued internally.
REQ-027 Changes on req_valid or req_data outside IDLE SHALL have no effect on the operation in flight.
REQ-028 If rsp_ready is held high before rsp_valid rises, the response SHALL complete on the first RESP cycle.
REQ-029 With NREQ<4, unused upper rsp_id bits SHALL be 0 and rr_ptr SHALL never exceed NREQ-1.

Reset
REQ-030 When rst_n=0, the block SHALL immediately and asynchronously set:
- FSM to IDLE;
- rr_ptr, operand register (hence cm_in), rsp_data and rsp_id to 0;
- rsp_valid and busy to 0;
- op_count to 0.
REQ-031 Reset asserted mid-operation SHALL abort that operation; no response is produced and op_count is unchanged from 0.
REQ-032 The block SHALL not accept a request in the first cycle after rst_n deasserts; arbitration starts with the first rising edge after deassertion.

Verification
REQ-033 Single request: req_valid=4'b0100, req_data[11:8]=4'hA, rsp_ready=1 -> req_ready=4'b0100 for one cycle; rsp_valid 2 cycles later with rsp_data equal to the model of custom_matrix(4'hA), rsp_id=2, op_count=1.
REQ-034 Round-robin fairness: all four req_valid bits held high, rsp_ready=1 -> grant order 0,1,2,3,0 over five operations; each accept is spaced 3 cycles apart.
REQ-035 Backpressure: rsp_ready=0 for 5 cycles after rsp_valid rises -> rsp_data and rsp_id stable, req_ready=0, busy=1 throughout; completion happens in the cycle rsp_ready=1 is sampled.
REQ-036 Reset mid-op: rst_n pulled low during ISSUE -> all outputs zero at once; after release, a new request on requester 3 is granted first because rr_ptr=0 and it is the only valid requester.
REQ-037 Counter wrap: run 256 operations -> op_count returns to 0; operand changes while busy do not alter the in-flight rsp_data.
